// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between imem and dmem
// One outstanding transaction; responses routed to the owner; busy timeout abandons lost responses.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_in_req_addr,
    input  logic [31:0] imem_in_req_data,
    input  logic [1:0]  imem_in_req_fcn,
    input  logic [2:0]  imem_in_req_typ,
    input  logic        imem_in_req_valid,
    output logic        imem_out_req_ready,
    output logic        imem_out_res_valid,
    output logic [31:0] imem_out_res_data,
    input  logic [31:0] dmem_in_req_addr,
    input  logic [31:0] dmem_in_req_data,
    input  logic [1:0]  dmem_in_req_fcn,
    input  logic [2:0]  dmem_in_req_typ,
    input  logic        dmem_in_req_valid,
    output logic        dmem_out_req_ready,
    output logic        dmem_out_res_valid,
    output logic [31:0] dmem_out_res_data,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [1:0]  mem_req_fcn,
    output logic [2:0]  mem_req_typ,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    input  logic        mem_res_valid,
    input  logic [31:0] mem_res_data,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;          // 1 = dmem granted most recently
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;

    logic sel_d;
    logic any_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // On a tie, the requester that was not granted last wins.
    assign any_valid = imem_in_req_valid | dmem_in_req_valid;
    assign sel_d     = dmem_in_req_valid & (~imem_in_req_valid | ~last_q);

    always_comb begin
        state_d            = state_q;
        last_d             = last_q;
        cnt_d              = cnt_q;
        timeout_err_d      = 1'b0;
        mem_req_addr       = '0;
        mem_req_data       = '0;
        mem_req_fcn        = '0;
        mem_req_typ        = '0;
        mem_req_valid      = 1'b0;
        imem_out_req_ready = 1'b0;
        dmem_out_req_ready = 1'b0;
        imem_out_res_valid = 1'b0;
        dmem_out_res_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    mem_req_valid = 1'b1;
                    if (sel_d) begin
                        mem_req_addr       = dmem_in_req_addr;
                        mem_req_data       = dmem_in_req_data;
                        mem_req_fcn        = dmem_in_req_fcn;
                        mem_req_typ        = dmem_in_req_typ;
                        dmem_out_req_ready = mem_req_ready;
                    end else begin
                        mem_req_addr       = imem_in_req_addr;
                        mem_req_data       = imem_in_req_data;
                        mem_req_fcn        = imem_in_req_fcn;
                        mem_req_typ        = imem_in_req_typ;
                        imem_out_req_ready = mem_req_ready;
                    end
                    if (mem_req_ready) begin
                        state_d = sel_d ? BUSY_D : BUSY_I;
                        last_d  = sel_d;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_res_valid) begin
                    imem_out_res_valid = (state_q == BUSY_I);
                    dmem_out_res_valid = (state_q == BUSY_D);
                    state_d            = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_out_res_data = mem_res_data;
    assign dmem_out_res_data = mem_res_data;
    assign timeout_err       = timeout_err_q;

endmodule
